// File: rtl/dac_sample_interp.sv
// Stereo linear interpolator: holds each input sample for 2^INTERP_LOG2
// modulator ticks, stepping per-channel accumulators from cur toward tgt.
// Ports: clk, resetn (async, active-high), in_valid/in_ready/in_left/in_right
// sample handshake, tick load strobe, out_left/out_right/out_valid result,
// flush sync clear, underrun sticky flag with underrun_clear.
module dac_sample_interp #(
   parameter int DATA_WIDTH  = 16,
   parameter int INTERP_LOG2 = 4
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] in_left,
   input  logic signed [DATA_WIDTH-1:0] in_right,
   input  logic                         tick,
   output logic signed [DATA_WIDTH-1:0] out_left,
   output logic signed [DATA_WIDTH-1:0] out_right,
   output logic                         out_valid,
   input  logic                         flush,
   output logic                         underrun,
   input  logic                         underrun_clear
);

   localparam int DW = DATA_WIDTH;
   localparam int L  = INTERP_LOG2;
   localparam int AW = DW + L + 1;

   typedef enum logic [1:0] {IDLE, PRIME, RUN, STALL} state_t;

   state_t                 state_q, state_d;
   logic [1:0][DW-1:0]     cur_q, cur_d;
   logic [1:0][DW-1:0]     tgt_q, tgt_d;
   logic [1:0][DW-1:0]     pend_q, pend_d;
   logic [1:0][DW-1:0]     out_q, out_d;
   logic [1:0][DW:0]       dlt_q, dlt_d;
   logic [1:0][AW-1:0]     acc_q, acc_d;
   logic                   pend_v_q, pend_v_d;
   logic [L-1:0]           step_q, step_d;
   logic                   ov_q, ov_d;
   logic                   ur_q, ur_d;

   logic [1:0][DW-1:0]     in_s;
   logic [1:0][DW-1:0]     nxt;
   logic                   accept;
   logic                   last;
   logic                   ur_set;

   // Index 0 is the left channel, 1 the right.
   assign in_s   = {in_right, in_left};
   assign accept = in_valid & in_ready;
   assign last   = (step_q == {L{1'b1}});

   assign in_ready  = ~resetn & ((state_q != RUN) | ~pend_v_q);
   assign out_left  = out_q[0];
   assign out_right = out_q[1];
   assign out_valid = ov_q;
   assign underrun  = ur_q;

   // Sample scaled into accumulator fixed point (L fractional bits).
   function automatic logic [AW-1:0] scale(input logic [DW-1:0] v);
      return {{(L+1){v[DW-1]}}, v} << L;
   endfunction

   function automatic logic [DW:0] diff(input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
      return {a[DW-1], a} - {b[DW-1], b};
   endfunction

   function automatic logic [AW-1:0] sext(input logic [DW:0] d);
      return {{L{d[DW]}}, d};
   endfunction

   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      tgt_d    = tgt_q;
      pend_d   = pend_q;
      out_d    = out_q;
      dlt_d    = dlt_q;
      acc_d    = acc_q;
      pend_v_d = pend_v_q;
      step_d   = step_q;
      ov_d     = 1'b0;
      ur_set   = 1'b0;
      nxt      = pend_v_q ? pend_q : in_s;

      if (flush) begin
         state_d  = IDLE;
         cur_d    = '0;
         tgt_d    = '0;
         pend_d   = '0;
         out_d    = '0;
         dlt_d    = '0;
         acc_d    = '0;
         pend_v_d = 1'b0;
         step_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (tick) begin
                  out_d = '0;
                  ov_d  = 1'b1;
               end
               if (accept) begin
                  cur_d   = in_s;
                  state_d = PRIME;
               end
            end
            PRIME: begin
               if (tick) ov_d = 1'b1;
               if (accept) begin
                  for (int c = 0; c < 2; c++) begin
                     tgt_d[c] = in_s[c];
                     dlt_d[c] = diff(in_s[c], cur_q[c]);
                     acc_d[c] = scale(cur_q[c]);
                  end
                  step_d  = '0;
                  state_d = RUN;
               end
            end
            RUN: begin
               if (accept) begin
                  pend_d   = in_s;
                  pend_v_d = 1'b1;
               end
               if (tick) begin
                  ov_d   = 1'b1;
                  step_d = step_q + 1'b1;
                  for (int c = 0; c < 2; c++) begin
                     // Floor of acc / 2^L is a plain bit slice.
                     out_d[c] = acc_q[c][DW+L-1:L];
                     acc_d[c] = acc_q[c] + sext(dlt_q[c]);
                  end
                  if (last) begin
                     step_d = '0;
                     for (int c = 0; c < 2; c++) begin
                        cur_d[c] = tgt_q[c];
                        acc_d[c] = scale(tgt_q[c]);
                     end
                     // A sample arriving on the final step counts as
                     // pending, so the ramp continues seamlessly.
                     if (pend_v_q || accept) begin
                        for (int c = 0; c < 2; c++) begin
                           tgt_d[c] = nxt[c];
                           dlt_d[c] = diff(nxt[c], tgt_q[c]);
                        end
                        pend_v_d = 1'b0;
                     end else begin
                        dlt_d   = '0;
                        ur_set  = 1'b1;
                        state_d = STALL;
                     end
                  end
               end
            end
            STALL: begin
               if (tick) begin
                  out_d = cur_q;
                  ov_d  = 1'b1;
               end
               // acc already holds cur scaled from the underrun step.
               if (accept) begin
                  for (int c = 0; c < 2; c++) begin
                     tgt_d[c] = in_s[c];
                     dlt_d[c] = diff(in_s[c], cur_q[c]);
                  end
                  step_d  = '0;
                  state_d = RUN;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      ur_d = ur_set | (ur_q & ~underrun_clear);
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state_q  <= IDLE;
         cur_q    <= '0;
         tgt_q    <= '0;
         pend_q   <= '0;
         out_q    <= '0;
         dlt_q    <= '0;
         acc_q    <= '0;
         pend_v_q <= 1'b0;
         step_q   <= '0;
         ov_q     <= 1'b0;
         ur_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         tgt_q    <= tgt_d;
         pend_q   <= pend_d;
         out_q    <= out_d;
         dlt_q    <= dlt_d;
         acc_q    <= acc_d;
         pend_v_q <= pend_v_d;
         step_q   <= step_d;
         ov_q     <= ov_d;
         ur_q     <= ur_d;
      end
   end

endmodule

// File: doc/dac_sample_interp.md
DAC_SAMPLE_INTERP -- requirements
Module: dac_sample_interp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed sample width per channel.
REQ-002 SHALL have parameter INTERP_LOG2, default 4: log2 of the number of interpolation steps per input sample (N = 2^INTERP_LOG2).
REQ-003 SHALL have port clk, input, 1: system clock; all state on rising edge.
REQ-004 SHALL have port resetn, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: stereo sample offered.
REQ-006 SHALL have port in_ready, output, 1: block can accept a sample.
REQ-007 SHALL have port in_left / in_right, input, DATA_WIDTH each: signed two's-complement samples.
REQ-008 SHALL have port tick, input, 1: single-cycle modulator load strobe, one per output step.
REQ-009 SHALL have port out_left / out_right, output, DATA_WIDTH each: signed interpolated samples to the sigma-delta stage.
REQ-010 SHALL have port out_valid, output, 1: one-cycle pulse marking an updated output pair.
REQ-011 SHALL have port flush, input, 1: synchronous clear to IDLE.
REQ-012 SHALL have port underrun, output, 1: sticky underrun flag.
REQ-013 SHALL have port underrun_clear, input, 1: synchronous clear of underrun.

Function
REQ-014 SHALL implement a four-state FSM: IDLE, PRIME, RUN, STALL. Per channel it keeps cur, tgt (DATA_WIDTH), delta (DATA_WIDTH+1 signed), acc (DATA_WIDTH+INTERP_LOG2+1 signed), plus a shared one-entry pending register pend with flag pend_v and a step counter of INTERP_LOG2 bits.
REQ-015 SHALL accept a sample only on a cycle where in_valid and in_ready are both high.
REQ-016 IDLE: in_ready=1 and outputs held at 0; an accepted sample loads cur and moves to PRIME.
REQ-017 PRIME: in_ready=1; an accepted sample loads tgt, sets delta=tgt-cur, acc=cur<<<INTERP_LOG2 and step=0, and moves to RUN.
REQ-018 RUN: in_ready = ~pend_v; an accepted sample loads pend and sets pend_v.
REQ-019 RUN, on each tick: out <= acc>>>INTERP_LOG2 (arithmetic, floor); out_valid pulses the following cycle; acc += delta; step increments.
REQ-020 RUN, tick with step = N-1 and pend_v=1: cur<=tgt, tgt<=pend, delta<=pend-tgt, acc<=tgt<<<INTERP_LOG2, step<=0, pend_v<=0; stay in RUN.
REQ-021 RUN, tick with step = N-1, pend_v=0 and a sample accepted in the same cycle: the incoming sample is used as pend would be, with no underrun.
REQ-022 RUN, tick with step = N-1, pend_v=0 and no sample accepted: cur<=tgt, acc<=tgt<<<INTERP_LOG2, delta<=0, set underrun, move to STALL.
REQ-023 STALL: in_ready=1 and each tick outputs cur; an accepted sample loads tgt, sets delta=tgt-cur and step=0, and returns to RUN.
REQ-024 SHALL apply the same step/tick control to left and right; arithmetic is per channel and exact, with no saturation (outputs always lie between cur and tgt).
REQ-025 A tick in IDLE or PRIME SHALL produce out_valid with outputs at 0 (IDLE) or held (PRIME).
REQ-026 flush SHALL take priority over all other events: state<=IDLE, pend_v<=0, all datapath registers and outputs <=0, out_valid<=0. underrun is unaffected.
REQ-027 underrun_clear SHALL clear underrun unless a new underrun occurs in the same cycle; set wins.

Reset
REQ-028 SHALL, on resetn high and at any time including mid-RUN: state=IDLE; out_left=out_right=0; out_valid=0; underrun=0; pend_v=0; step=0; in_ready becomes 1 once resetn is released.

Verification
REQ-029 Ramp up (L=4): samples 0, then 160, then 0 pending; 16 ticks -> outputs 0,10,20,...,150, then 160 on tick 17; underrun=0.
REQ-030 Ramp down: 100, then -60 -> outputs 100,90,...,-50; values with floor rounding checked bit-exact against a reference model.
REQ-031 Extremes: -32768, then 32767 -> no overflow; step 15 output = 28671; next segment starts at 32767.
REQ-032 Underrun: supply only two samples -> after 16 ticks out holds 160 on every tick and underrun=1; feed 320 -> ramp 160,170,...; underrun_clear drops the flag.
REQ-033 Backpressure: pend full -> in_ready=0 and in_valid is held without data loss; same-cycle last-step tick plus accepted sample -> seamless continuation with no underrun.
REQ-034 Flush and reset mid-RUN -> next cycle outputs 0 and state IDLE; the next two samples re-prime correctly.
